// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the extended-Hamming (8,4) SECDED link.
//   - Codeword bit positions for the three Hamming parities, the overall
//     parity bit and the four data bits. The decoder on the receiving side
//     imports these same positions, so both ends always agree on the layout.
//   - estado_tx_t: states of the serial transmitter.
//   - codificar_hamming(): nibble -> 8-bit codeword.
package hamming_pkg;

  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_P3 = 3;
  localparam int POS_PG = 7;
  localparam int POS_D [4] = '{2, 4, 5, 6};

  typedef enum logic [1:0] {
    REPOSO,
    INICIO,
    DATOS,
    PARADA
  } estado_tx_t;

  // Each Hamming parity covers the data bits whose 1-based position has the
  // matching bit set, so the decoder syndrome of a clean word is zero.
  // The overall parity bit makes the whole word even, which lets the
  // decoder tell single from double errors.
  function automatic logic [7:0] codificar_hamming(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[POS_D[i]] = d[i];
    end
    c[POS_P1] = d[0] ^ d[1] ^ d[3];
    c[POS_P2] = d[0] ^ d[2] ^ d[3];
    c[POS_P3] = d[1] ^ d[2] ^ d[3];
    c[POS_PG] = ^c[6:0];
    return c;
  endfunction

endpackage

// File: rtl/codificador_hamming.sv
// codificador_hamming
// Purely combinational nibble-to-codeword encoder.
//   dato   in  4  data nibble
//   codigo out 8  extended-Hamming codeword (no error mask applied)
module codificador_hamming
  import hamming_pkg::*;
(
  input  logic [3:0] dato,
  output logic [7:0] codigo
);

  assign codigo = codificar_hamming(dato);

endmodule

// File: rtl/codificador_serial.sv
// codificador_serial
// Transmitter for the Hamming SECDED serial link. Captures a nibble on a
// valid/ready handshake, encodes it, XORs in an optional error-injection
// mask and sends the resulting byte as a UART-style frame:
// start bit (0), palabra[0..7] LSB first, stop bit (1), each bit held for
// CICLOS_POR_BIT clock cycles.
//   reloj          in   1  clock, rising edge
//   reinicio       in   1  synchronous active-high reset
//   dato           in   4  nibble to send
//   mascara_error  in   8  XORed into the codeword at capture
//   valido         in   1  dato / mascara_error are valid
//   listo          out  1  idle, a transfer is accepted this cycle
//   tx             out  1  serial line, idles high (registered)
//   tx_activo      out  1  a frame is on the line
//   palabra        out  8  registered codeword being sent (mask applied)
//   hecho          out  1  one-cycle pulse in the last stop-bit cycle
module codificador_serial
  import hamming_pkg::*;
#(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic       reloj,
  input  logic       reinicio,
  input  logic [3:0] dato,
  input  logic [7:0] mascara_error,
  input  logic       valido,
  output logic       listo,
  output logic       tx,
  output logic       tx_activo,
  output logic [7:0] palabra,
  output logic       hecho
);

  localparam int ANCHO_CONT = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [ANCHO_CONT-1:0] CONT_FIN = ANCHO_CONT'(CICLOS_POR_BIT - 1);

  estado_tx_t            estado_q, estado_d;
  logic [ANCHO_CONT-1:0] contador_q, contador_d;
  logic [2:0]            indice_q, indice_d;
  logic [7:0]            palabra_q, palabra_d;
  logic                  tx_q, tx_d;

  logic [7:0] codigo;
  logic       handshake;
  logic       fin_bit;

  codificador_hamming u_codificador_hamming (
    .dato   (dato),
    .codigo (codigo)
  );

  assign handshake = valido && (estado_q == REPOSO);
  assign fin_bit   = (contador_q == CONT_FIN);

  // State register
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      estado_q   <= REPOSO;
      contador_q <= '0;
      indice_q   <= '0;
      palabra_q  <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      indice_q   <= indice_d;
      palabra_q  <= palabra_d;
      tx_q       <= tx_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    indice_d   = indice_q;
    palabra_d  = palabra_q;

    // The bit-time counter runs in every non-idle state and wraps each bit.
    if (estado_q != REPOSO) begin
      contador_d = fin_bit ? '0 : contador_q + 1'b1;
    end

    unique case (estado_q)
      REPOSO: begin
        contador_d = '0;
        indice_d   = '0;
        if (handshake) begin
          estado_d  = INICIO;
          palabra_d = codigo ^ mascara_error;
        end
      end
      INICIO: begin
        if (fin_bit) begin
          estado_d = DATOS;
          indice_d = '0;
        end
      end
      DATOS: begin
        if (fin_bit) begin
          // 3-bit index wraps 7 -> 0 on the way into the stop bit.
          indice_d = indice_q + 3'd1;
          if (indice_q == 3'd7) begin
            estado_d = PARADA;
          end
        end
      end
      PARADA: begin
        if (fin_bit) begin
          estado_d = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // Output logic. tx is registered, so its next value is derived from the
  // next state: the line changes on the same edge as the state.
  always_comb begin
    listo     = (estado_q == REPOSO);
    tx_activo = (estado_q != REPOSO);
    hecho     = (estado_q == PARADA) && fin_bit;
    tx_d      = 1'b1;
    case (estado_d)
      INICIO:  tx_d = 1'b0;
      DATOS:   tx_d = palabra_q[indice_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign palabra = palabra_q;

endmodule
